bus_ram_responder: RTL and testbench

//  Responder (slave) end of the CPU system bus: a word-organised RAM that answers rd_bus/wr_bus

---
 rtl/bus_ram_responder.sv | 129 ++++++++++++
 tb/tb_bus_ram_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_ram_responder.sv
// Word-organised RAM responder on the shared CPU bus: windowed decode, byte-lane masks,
// programmable wait states and a 4-phase fc_bus handshake; bus outputs are high-Z unless selected.
module bus_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_bus,
    inout  wire  [31:0] data_bus,
    input  logic        rd_bus,
    input  logic        wr_bus,
    input  logic [3:0]  data_mask_bus,
    output wire         fc_bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam int unsigned WORDS     = 1 << ADDR_BITS;
    localparam logic [32:0] WIN_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI    = WIN_LO + (33'd4 << ADDR_BITS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   word_q, word_d;
    logic [1:0]             off_q, off_d;
    logic [3:0]             mask_q, mask_d;
    logic                   is_wr_q, is_wr_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [31:0]            mem_q [WORDS];

    logic                   req;
    logic                   sel;
    logic                   commit;
    logic [31:0]            rd_shift;
    logic [31:0]            rd_val;
    logic [31:0]            wr_shift;
    logic [3:0]             wr_be;
    logic                   drive_rd;

    assign req    = rd_bus | wr_bus;
    assign sel    = req && ({1'b0, addr_bus} >= WIN_LO) && ({1'b0, addr_bus} < WIN_HI);
    assign commit = (state_q == S_WAIT) && req && (cnt_q == 4'd0);

    // Right-justified lanes: shift toward the addressed byte; bytes past the word edge fall off.
    assign rd_shift = mem_q[word_q] >> {off_q, 3'b000};
    assign wr_shift = data_bus << {off_q, 3'b000};
    assign wr_be    = mask_q << off_q;

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (mask_q[i]) rd_val[8*i +: 8] = rd_shift[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        off_d   = off_q;
        mask_d  = mask_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_INIT;
                    word_d  = addr_bus[ADDR_BITS+1:2];
                    off_d   = addr_bus[1:0];
                    mask_d  = data_mask_bus;
                    is_wr_d = wr_bus;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    if (!is_wr_q) rdata_d = rd_val;
                end
            end
            S_DONE: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            off_q   <= '0;
            mask_q  <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            off_q   <= off_d;
            mask_q  <= mask_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately outside reset; commit is gated by the reset state register.
    always_ff @(posedge clk) begin
        if (commit && is_wr_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i]) mem_q[word_q][8*i +: 8] <= wr_shift[8*i +: 8];
            end
        end
    end

    assign drive_rd = (state_q == S_DONE) && rd_bus && !wr_bus && !is_wr_q;
    assign data_bus = drive_rd ? rdata_q : 'z;
    assign fc_bus   = (state_q == S_DONE) ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: two instances (1 and 3 wait states) on pulled bus nets,
// directed scenarios plus random traffic checked against a byte-array reference model.
module tb_bus_ram_responder;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_v [2];
    logic [31:0] wdat_v [2];
    logic [31:0] d_obs  [2];
    logic        rd_v   [2];
    logic        wr_v   [2];
    logic        drv_v  [2];
    logic        fc_obs [2];
    logic [3:0]  mask_v [2];
    int unsigned wst    [2] = '{1, 3};
    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  mdl [2][16384];

    always #5 clk = ~clk;

    // Undriven data_bus reads all-ones, undriven fc_bus reads zero.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        tri1 [31:0] dbus;
        tri0        fc;
        assign dbus      = drv_v[g] ? wdat_v[g] : 'z;
        assign d_obs[g]  = dbus;
        assign fc_obs[g] = fc;
        bus_ram_responder #(
            .BASE_ADDR  (BASE),
            .ADDR_BITS  (12),
            .WAIT_STATES(g == 0 ? 1 : 3)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .addr_bus     (addr_v[g]),
            .data_bus     (dbus),
            .rd_bus       (rd_v[g]),
            .wr_bus       (wr_v[g]),
            .data_mask_bus(mask_v[g]),
            .fc_bus       (fc)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_read(int d, logic [31:0] a, logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (int'(a[1:0]) + i) <= 3) r[8*i +: 8] = mdl[d][int'(a[13:0]) + i];
        end
        return r;
    endfunction

    task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] m);
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (int'(a[1:0]) + i) <= 3) mdl[d][int'(a[13:0]) + i] = wd[8*i +: 8];
        end
    endtask

    task automatic txn(input int d, input logic [31:0] a, input logic w, input logic r,
                       input logic [31:0] wd, input logic [3:0] m, output logic [31:0] rdout);
        int lat;
        lat = int'(wst[d]);
        @(negedge clk);
        addr_v[d] = a; wr_v[d] = w; rd_v[d] = r; mask_v[d] = m;
        drv_v[d] = w; wdat_v[d] = wd;
        for (int k = 0; k <= lat + 1; k++) begin
            @(negedge clk);
            chk($sformatf("fc_lat_i%0d_k%0d", d, k), 32'(fc_obs[d]), (k == lat + 1) ? 32'd1 : 32'd0);
        end
        rdout = d_obs[d];
        if (w) mdl_write(d, a, wd, m);
        else   chk($sformatf("rdata_i%0d_%h", d, a), d_obs[d], mdl_read(d, a, m));
        rd_v[d] = 1'b0; wr_v[d] = 1'b0; drv_v[d] = 1'b0;
        #1;
        chk("data_release", d_obs[d], 32'hFFFF_FFFF);
        chk("fc_hold", 32'(fc_obs[d]), 32'd1);
        @(negedge clk);
        chk("fc_drop", 32'(fc_obs[d]), 32'd0);
    endtask

    task automatic oow(input int d, input logic [31:0] a);
        @(negedge clk);
        addr_v[d] = a; rd_v[d] = 1'b1; wr_v[d] = 1'b0; mask_v[d] = 4'hF; drv_v[d] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("oow_fc", 32'(fc_obs[d]), 32'd0);
            chk("oow_data", d_obs[d], 32'hFFFF_FFFF);
        end
        rd_v[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rdv;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  m;
        int          d;
        int          kind;

        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = '0; wdat_v[i] = '0; rd_v[i] = 1'b0; wr_v[i] = 1'b0;
            drv_v[i] = 1'b0; mask_v[i] = 4'hF;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_fc", 32'(fc_obs[i]), 32'd0);
            chk("reset_data", d_obs[i], 32'hFFFF_FFFF);
        end
        rst = 1'b1;

        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 64; w++) txn(i, BASE + 32'(4 * w), 1'b1, 1'b0, $urandom, 4'hF, rdv);
            txn(i, BASE + 32'h3FFC, 1'b1, 1'b0, $urandom, 4'hF, rdv);
        end

        // Full word write then read back.
        txn(0, BASE + 32'h10, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, rdv);
        txn(0, BASE + 32'h10, 1'b0, 1'b1, '0, 4'hF, rdv);
        chk("t1_word", rdv, 32'hDEAD_BEEF);

        // Byte and half-word lanes.
        txn(0, BASE + 32'h10, 1'b1, 1'b0, 32'h1122_3344, 4'hF, rdv);
        txn(0, BASE + 32'h13, 1'b1, 1'b0, 32'h0000_00AA, 4'h1, rdv);
        txn(0, BASE + 32'h10, 1'b0, 1'b1, '0, 4'hF, rdv);
        chk("t2_word", rdv, 32'hAA22_3344);
        txn(0, BASE + 32'h12, 1'b0, 1'b1, '0, 4'h3, rdv);
        chk("t2_half", rdv, 32'h0000_AA22);

        // Lanes past the word edge are dropped.
        txn(0, BASE + 32'h20, 1'b1, 1'b0, 32'h0, 4'hF, rdv);
        txn(0, BASE + 32'h24, 1'b1, 1'b0, 32'h5555_5555, 4'hF, rdv);
        txn(0, BASE + 32'h23, 1'b1, 1'b0, 32'h0000_BBCC, 4'h3, rdv);
        txn(0, BASE + 32'h20, 1'b0, 1'b1, '0, 4'hF, rdv);
        chk("t3_word20", rdv, 32'hCC00_0000);
        txn(0, BASE + 32'h24, 1'b0, 1'b1, '0, 4'hF, rdv);
        chk("t3_word24", rdv, 32'h5555_5555);
        txn(0, BASE + 32'h22, 1'b0, 1'b1, '0, 4'hF, rdv);
        chk("t3_shift", rdv, 32'h0000_CC00);

        oow(0, 32'h3FFF_FFFC);
        oow(0, 32'h4000_4000);
        txn(0, BASE + 32'h3FFC, 1'b0, 1'b1, '0, 4'hF, rdv);

        // Aborted write on the 3-wait-state instance, then a real one.
        @(negedge clk);
        addr_v[1] = BASE + 32'h40; wr_v[1] = 1'b1; rd_v[1] = 1'b0; mask_v[1] = 4'hF;
        drv_v[1] = 1'b1; wdat_v[1] = 32'hA5A5_A5A5;
        repeat (2) begin
            @(negedge clk);
            chk("t5_nofc", 32'(fc_obs[1]), 32'd0);
        end
        wr_v[1] = 1'b0; drv_v[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t5_dropped", 32'(fc_obs[1]), 32'd0);
        end
        txn(1, BASE + 32'h40, 1'b0, 1'b1, '0, 4'hF, rdv);
        txn(1, BASE + 32'h40, 1'b1, 1'b0, 32'hA5A5_A5A5, 4'hF, rdv);
        txn(1, BASE + 32'h40, 1'b0, 1'b1, '0, 4'hF, rdv);
        chk("t5_commit", rdv, 32'hA5A5_A5A5);

        // Reset while a write waits.
        @(negedge clk);
        addr_v[1] = BASE + 32'h44; wr_v[1] = 1'b1; rd_v[1] = 1'b0; mask_v[1] = 4'hF;
        drv_v[1] = 1'b1; wdat_v[1] = 32'h0BAD_F00D;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_fc_rst", 32'(fc_obs[1]), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_fc_held", 32'(fc_obs[1]), 32'd0);
        end
        wr_v[1] = 1'b0; drv_v[1] = 1'b0; rst = 1'b1;
        #1;
        chk("t6_data_rel", d_obs[1], 32'hFFFF_FFFF);
        repeat (6) begin
            @(negedge clk);
            chk("t6_idle", 32'(fc_obs[1]), 32'd0);
        end
        txn(1, BASE + 32'h44, 1'b0, 1'b1, '0, 4'hF, rdv);
        txn(0, BASE + 32'h10, 1'b0, 1'b1, '0, 4'hF, rdv);
        chk("t6_preserved", rdv, 32'hAA22_3344);

        for (int n = 0; n < 60; n++) begin
            d    = int'($urandom_range(0, 1));
            a    = BASE + 32'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 2));
            wd   = $urandom;
            case ($urandom_range(0, 3))
                0:       m = 4'h1;
                1:       m = 4'h3;
                2:       m = 4'hF;
                default: m = 4'($urandom);
            endcase
            txn(d, a, kind != 0, kind != 1, wd, m, rdv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
